// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: EX/fetch master ports, memory slave port and status lines bundled around the arbiter
interface bus_arbiter_if;
  logic        m0_req_i, m0_we_i, m0_ack_o, m1_req_i, m1_ack_o;
  logic        s_req_o, s_we_o, s_ack_i, hold_o, err_o;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o, m1_addr_i, m1_data_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  modport master (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m1_req_i, m1_addr_i, s_data_i, s_ack_i,
    output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o, s_req_o, s_we_o, s_addr_o, s_data_o, hold_o, err_o
  );
  modport slave (
    output m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m1_req_i, m1_addr_i, s_data_i, s_ack_i,
    input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o, s_req_o, s_we_o, s_addr_o, s_data_o, hold_o, err_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed-priority (EX over fetch) serialiser of two masters onto one req/ack slave.
// Optional ARB_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES cycles without s_ack_i and pulses err_o.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.master b
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic gnt, go, done, tmo;
  logic [W-1:0] cnt;
  assign go = state == IDLE && (b.m0_req_i || b.m1_req_i);
  assign done = state == ACCESS && (b.s_ack_i || tmo);
  assign b.hold_o = (b.m0_req_i & ~b.m0_ack_o) | (b.m1_req_i & ~b.m1_ack_o);
`ifdef ARB_TIMEOUT_EN
  // an ack in the terminal-count cycle takes precedence over the abort
  assign tmo = state == ACCESS && !b.s_ack_i && cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= go ? '0 : state == ACCESS ? cnt + 1'b1 : cnt;
`else
  assign tmo = 1'b0;
  assign cnt = '0;
`endif
  always_comb begin
    state_n = state == IDLE ? (go ? ACCESS : IDLE) : state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt         <= 1'b0;
      b.s_req_o   <= 1'b0;
      b.s_we_o    <= 1'b0;
      b.s_addr_o  <= '0;
      b.s_data_o  <= '0;
      b.m0_data_o <= '0;
      b.m1_data_o <= '0;
      b.m0_ack_o  <= 1'b0;
      b.m1_ack_o  <= 1'b0;
      b.err_o     <= 1'b0;
    end else begin
      b.m0_ack_o <= done && !gnt;
      b.m1_ack_o <= done && gnt;
      b.err_o    <= done && tmo && !(cnt == '1 && tmo == 1'b0);
      if (go) begin
        gnt        <= !b.m0_req_i;
        b.s_req_o  <= 1'b1;
        b.s_we_o   <= b.m0_req_i && b.m0_we_i;
        b.s_addr_o <= b.m0_req_i ? b.m0_addr_i : b.m1_addr_i;
        b.s_data_o <= b.m0_req_i ? b.m0_data_i : '0;
      end
      if (done) begin
        b.s_req_o <= 1'b0;
        if (!gnt) b.m0_data_o <= (tmo || b.s_we_o) ? '0 : b.s_data_i;
        else b.m1_data_o <= tmo ? '0 : b.s_data_i;
      end
    end
endmodule
